// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator and instruction-fetch request front end.
// Holds the fetch PC, issues valid/ready requests to instruction memory and
// redirects on taken branches, JAL and JALR from the execute stage.
//
// Optional feature macro: PC_GEN_MISALIGN_TRAP_EN
//   defined   -> a redirect target with bit 1 set is replaced by TRAP_VEC and
//                the sticky misalign flag is raised
//   undefined -> targets pass through unchanged, misalign is tied to 0
//
// state | meaning
// IDLE  | no fetch request outstanding
// REQ   | request outstanding, no redirect waiting
// PEND  | request outstanding, redirect target parked in pend_pc
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [6:0]  opc,
  input  logic        br_taken,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] pc,
  output logic        resp_kill,
  output logic        flush,
  output logic        misalign
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        redirect;
  logic        handshake;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pend_pc;

  // redirect decode and raw target arithmetic (32-bit modulo)
  always_comb begin
    redirect = ex_valid & (((opc == OPC_BRANCH) & br_taken) |
                           (opc == OPC_JAL) | (opc == OPC_JALR));
    if (opc == OPC_JALR) target_raw = (rs1 + imm) & ~32'h1;
    else                 target_raw = pc_ex + imm;
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic misalign_q;

  assign target   = target_raw[1] ? TRAP_VEC : target_raw;
  assign misalign = misalign_q;

  // sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            misalign_q <= 1'b0;
    else if (redirect & target_raw[1])  misalign_q <= 1'b1;
  end
`else
  logic [31:0] unused_trap_vec;

  assign unused_trap_vec = TRAP_VEC;
  assign target          = target_raw;
  assign misalign        = 1'b0;
`endif

  assign handshake = req_valid & req_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; once raised, the request holds until its handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = stall ? IDLE : REQ;
      REQ: begin
        if (handshake)     state_nxt = stall ? IDLE : REQ;
        else if (redirect) state_nxt = PEND;
      end
      PEND: begin
        if (handshake)     state_nxt = stall ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state; wrong-path kill on a handshake that is stale
  always_comb begin
    req_valid = (state != IDLE);
    resp_kill = req_valid & req_ready & ((state == PEND) | redirect);
  end

  // fetch pc and parked redirect target; pc stays put while a request waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= target;
        end
        REQ: begin
          if (handshake)     pc      <= redirect ? target : pc + 32'd4;
          else if (redirect) pend_pc <= target;
        end
        PEND: begin
          if (handshake)     pc      <= redirect ? target : pend_pc;
          else if (redirect) pend_pc <= target;
        end
        default: ;
      endcase
    end
  end

  // one-cycle flush per redirect; back-to-back redirects keep it high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush <= 1'b0;
    else     flush <= redirect;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic, checked by
// a scoreboard fed from a transaction-level reference model.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0080;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [6:0]  BR   = 7'b1100011;
  localparam logic [6:0]  JAL  = 7'b1101111;
  localparam logic [6:0]  JALR = 7'b1100111;
  localparam logic [6:0]  ALU  = 7'b0110011;
  localparam logic [6:0]  LD   = 7'b0000011;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [6:0]  opc;
  logic        br_taken;
  logic [31:0] pc_ex;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] pc;
  logic        resp_kill;
  logic        flush;
  logic        misalign;

  pc_gen #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .ex_valid  (ex_valid),
    .opc       (opc),
    .br_taken  (br_taken),
    .pc_ex     (pc_ex),
    .imm       (imm),
    .rs1       (rs1),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .pc        (pc),
    .resp_kill (resp_kill),
    .flush     (flush),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        k;
    logic        f;
    logic        m;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // reference model: an outstanding-request flag plus an optional parked target
  logic        m_busy;
  logic [31:0] m_pc;
  logic        m_has_pend;
  logic [31:0] m_pend;
  logic        m_flush;
  logic        m_mis;

  task automatic check(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", name, n, act, exp);
    end
  endtask

  // expected outputs for the current cycle, then advance model across the next edge
  task automatic apply();
    logic        redir;
    logic        hs;
    logic [31:0] tgt;
    exp_t        e;
    redir = ex_valid && ((opc == BR && br_taken) || opc == JAL || opc == JALR);
    tgt   = (opc == JALR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc_ex + imm);
    hs    = m_busy && req_ready;
    e.v  = m_busy;
    e.pc = m_pc;
    e.k  = hs && (m_has_pend || redir);
    e.f  = m_flush;
    e.m  = m_mis;
    e.n  = cyc;
    cyc++;
    sb.push_back(e);
`ifdef PC_GEN_MISALIGN_TRAP_EN
    if (redir && tgt[1]) begin
      m_mis = 1'b1;
      tgt   = TRAP_VEC;
    end
`endif
    m_flush = redir;
    if (!m_busy) begin
      if (redir) m_pc = tgt;
      m_busy = !stall;
    end else if (hs) begin
      m_pc       = redir ? tgt : (m_has_pend ? m_pend : m_pc + 32'd4);
      m_has_pend = 1'b0;
      m_busy     = !stall;
    end else if (redir) begin
      m_has_pend = 1'b1;
      m_pend     = tgt;
    end
  endtask

  task automatic cycle(input logic st, input logic ev, input logic [6:0] op,
                       input logic br, input logic [31:0] pe, input logic [31:0] im,
                       input logic [31:0] r1, input logic rdy);
    @(posedge clk);
    #1;
    stall = st; ex_valid = ev; opc = op; br_taken = br;
    pc_ex = pe; imm = im; rs1 = r1; req_ready = rdy;
    apply();
  endtask

  task automatic idle(input logic st, input logic rdy);
    cycle(st, 1'b0, ALU, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  // reset asserted mid-cycle: outputs must clear immediately
  task automatic do_reset(input logic st, input logic rdy);
    @(posedge clk);
    #7;
    rst = 1'b1;
    #1;
    check("rst_req_valid", cyc, {31'h0, req_valid}, 32'h0);
    check("rst_pc",        cyc, pc, RESET_PC);
    check("rst_flush",     cyc, {31'h0, flush}, 32'h0);
    check("rst_resp_kill", cyc, {31'h0, resp_kill}, 32'h0);
    check("rst_misalign",  cyc, {31'h0, misalign}, 32'h0);
    m_busy = 1'b0; m_pc = RESET_PC; m_has_pend = 1'b0; m_pend = 32'h0;
    m_flush = 1'b0; m_mis = 1'b0;
    stall = st; ex_valid = 1'b0; opc = ALU; br_taken = 1'b0;
    pc_ex = 32'h0; imm = 32'h0; rs1 = 32'h0; req_ready = rdy;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    apply();
  endtask

  // monitor: pops one expected record per cycle and compares away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_valid", e.n, {31'h0, req_valid}, {31'h0, e.v});
        check("pc",        e.n, pc, e.pc);
        check("resp_kill", e.n, {31'h0, resp_kill}, {31'h0, e.k});
        check("flush",     e.n, {31'h0, flush}, {31'h0, e.f});
        check("misalign",  e.n, {31'h0, misalign}, {31'h0, e.m});
      end
    end
  end

  initial begin
    logic [6:0] ops [5];
    int         drain;
    ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ALU; ops[4] = LD;
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; opc = ALU; br_taken = 1'b0;
    pc_ex = 32'h0; imm = 32'h0; rs1 = 32'h0; req_ready = 1'b1;

    // sequential fetch from RESET_PC
    do_reset(1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b1);

    // taken BEQ with handshake, back to 0xF0
    cycle(1'b0, 1'b1, BR, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b1);
    repeat (2) idle(1'b0, 1'b1);
    // not-taken branch: no redirect
    cycle(1'b0, 1'b1, BR, 1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b1);

    // JALR while memory stalls, parked until the handshake
    cycle(1'b0, 1'b1, JALR, 1'b0, 32'h0, 32'h4, 32'h203, 1'b0);
    repeat (3) idle(1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b1);

    // JAL to a target with bit 1 set, then an aligned JAL
    cycle(1'b0, 1'b1, JAL, 1'b0, 32'h200, 32'h2, 32'h0, 1'b1);
    idle(1'b0, 1'b1);
    cycle(1'b0, 1'b1, JAL, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1);
    idle(1'b0, 1'b1);

    // stall during an outstanding request
    repeat (3) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    repeat (2) idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b1);

    // redirect near the top of memory and wrap past zero
    cycle(1'b0, 1'b1, JAL, 1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0, 1'b1);
    repeat (3) idle(1'b0, 1'b1);

    // back-to-back redirects, last parked redirect wins
    cycle(1'b0, 1'b1, JAL, 1'b0, 32'h1000, 32'h10, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, JAL, 1'b0, 32'h2000, 32'h20, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, BR,  1'b1, 32'h3000, 32'h30, 32'h0, 1'b1);
    repeat (2) idle(1'b0, 1'b1);

    // reset while a redirect is parked
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b1, JALR, 1'b0, 32'h0, 32'h4, 32'h400, 1'b0);
    idle(1'b0, 1'b0);
    do_reset(1'b0, 1'b1);
    repeat (3) idle(1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] im;
      if ($urandom_range(0, 3) == 0) im = $urandom;
      else im = 32'($urandom_range(0, 63) * 4) - 32'd128;
      if (i % 700 == 699) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 3),
            ops[$urandom_range(0, 4)],
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
            im,
            $urandom,
            ($urandom_range(0, 9) < 6));
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
